// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports and the Data_mem side
// of the data-memory arbiter.
//   slave  : arbiter view (requests/memory read data in, grants/strobes out)
//   master : environment view (loader/pipeline/memory), the mirror image
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // requester port 0 (CPU memory stage)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;
    // requester port 1 (UART loader)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;
    // status and memory side
    logic              busy;
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, d_out,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
               busy, m_read, m_write, addr, d_in
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, d_out,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
               busy, m_read, m_write, addr, d_in
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported Data_mem between the CPU memory
// stage (port 0, fixed priority) and the UART loader (port 1). One access at
// a time: writes take one cycle, reads take two (issue, data return).
// A saturating wait counter lets port 1 win once it has waited STARVE_LIMIT
// consecutive cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave (requests, grants, read returns, memory side)
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        bus.gnt0    = 1'b0;
        bus.gnt1    = 1'b0;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.addr    = '0;
        bus.d_in    = '0;
        bus.rvalid0 = 1'b0;
        bus.rvalid1 = 1'b0;
        bus.rdata0  = '0;
        bus.rdata1  = '0;
        bus.busy    = 1'b0;

        // Outputs are forced quiet while reset is held; this is also what
        // drops the return of a read interrupted by reset.
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bus.req1 && (!bus.req0 || starve_cnt == LIMIT)) begin
                        bus.gnt1    = 1'b1;
                        bus.addr    = bus.addr1;
                        bus.d_in    = bus.wdata1;
                        bus.m_write = bus.we1;
                        bus.m_read  = !bus.we1;
                        if (!bus.we1) begin
                            state_nxt = RD_WAIT;
                            owner_nxt = 1'b1;
                        end
                    end else if (bus.req0) begin
                        bus.gnt0    = 1'b1;
                        bus.addr    = bus.addr0;
                        bus.d_in    = bus.wdata0;
                        bus.m_write = bus.we0;
                        bus.m_read  = !bus.we0;
                        if (!bus.we0) begin
                            state_nxt = RD_WAIT;
                            owner_nxt = 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    // memory returns d_out one cycle after m_read
                    bus.busy  = 1'b1;
                    state_nxt = IDLE;
                    if (owner) begin
                        bus.rvalid1 = 1'b1;
                        bus.rdata1  = bus.d_out;
                    end else begin
                        bus.rvalid0 = 1'b1;
                        bus.rdata0  = bus.d_out;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Port 1 wait counter: counts every cycle it is left waiting,
        // including RD_WAIT cycles, and saturates at the limit.
        if (!bus.req1 || bus.gnt1)
            starve_nxt = '0;
        else if (starve_cnt != LIMIT)
            starve_nxt = starve_cnt + 1'b1;
        else
            starve_nxt = starve_cnt;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a read-return scoreboard.
// A reference memory is updated from the write payloads the bench drives;
// every granted read pushes the expected port/data, popped on rvalid.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_mem stand-in: write captured at the edge, read data next cycle
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        b.d_out = '0;
    end
    always @(posedge clk) begin
        if (b.m_write) mem[b.addr[9:2]] <= b.d_in;
        if (b.m_read)  b.d_out <= mem[b.addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            chk("rvalid_onehot", 32'(b.rvalid0 & b.rvalid1), 32'h0);
            if (b.rvalid0 || b.rvalid1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_port", 32'(b.rvalid1), 32'(e.port));
                    chk("sb_data", b.rvalid1 ? b.rdata1 : b.rdata0, e.data);
                end
            end
            if (b.gnt0) begin
                chk("addr_p0", b.addr, b.addr0);
                if (b.we0) ref_mem[b.addr0[9:2]] = b.wdata0;
                else       sb.push_back('{1'b0, ref_mem[b.addr0[9:2]]});
            end
            if (b.gnt1) begin
                chk("addr_p1", b.addr, b.addr1);
                if (b.we1) ref_mem[b.addr1[9:2]] = b.wdata1;
                else       sb.push_back('{1'b1, ref_mem[b.addr1[9:2]]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // port 0 streams reads, port 1 holds a read; count cycles until gnt1
    task automatic starve_run(input string tag);
        int n;
        n = 0;
        cyc();
        b.req0 = 1'b1; b.we0 = 1'b0; b.addr0 = 32'h10;
        b.req1 = 1'b1; b.we1 = 1'b0; b.addr1 = 32'h20;
        #4;
        while (!b.gnt1 && n < 20) begin
            n++;
            cyc();
            #4;
        end
        chk(tag, 32'(n), 32'd4);
        cyc();
        b.req1 = 1'b0;
        #4;
        chk({tag, "_rvalid1"}, 32'(b.rvalid1), 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 32'h40; b.wdata0 = 32'h1111_1111;
        b.req1 = 1'b1; b.we1 = 1'b0; b.addr1 = 32'h44; b.wdata1 = '0;

        // reset held with both requests high
        repeat (2) begin
            cyc();
            #4;
            chk("rst_gnt0",    32'(b.gnt0),    32'h0);
            chk("rst_gnt1",    32'(b.gnt1),    32'h0);
            chk("rst_m_write", 32'(b.m_write), 32'h0);
            chk("rst_m_read",  32'(b.m_read),  32'h0);
            chk("rst_addr",    b.addr,         32'h0);
            chk("rst_d_in",    b.d_in,         32'h0);
            chk("rst_busy",    32'(b.busy),    32'h0);
        end
        cyc();
        rst = 1'b0;
        #4;
        chk("post_rst_gnt0", 32'(b.gnt0), 32'h1);
        chk("post_rst_gnt1", 32'(b.gnt1), 32'h0);

        cyc();
        b.req0 = 1'b0; b.req1 = 1'b0;
        #4;
        chk("idle_gnt0", 32'(b.gnt0), 32'h0);
        chk("idle_strobes", 32'({b.m_read, b.m_write}), 32'h0);

        // port 0 write then read
        cyc();
        b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 32'h10; b.wdata0 = 32'hDEAD_BEEF;
        #4;
        chk("wr_gnt0", 32'(b.gnt0), 32'h1);
        chk("wr_m_write", 32'(b.m_write), 32'h1);
        chk("wr_m_read", 32'(b.m_read), 32'h0);
        chk("wr_d_in", b.d_in, 32'hDEAD_BEEF);
        cyc();
        b.we0 = 1'b0;
        #4;
        chk("rd_gnt0", 32'(b.gnt0), 32'h1);
        chk("rd_m_read", 32'(b.m_read), 32'h1);
        cyc();
        b.req0 = 1'b0;
        #4;
        chk("rd_rvalid0", 32'(b.rvalid0), 32'h1);
        chk("rd_rdata0", b.rdata0, 32'hDEAD_BEEF);
        chk("rd_rvalid1", 32'(b.rvalid1), 32'h0);
        chk("rd_rdata1", b.rdata1, 32'h0);
        chk("rd_busy", 32'(b.busy), 32'h1);

        // collision: port 0 write vs port 1 read of the same word
        cyc();
        b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 32'h20; b.wdata0 = 32'hCAFE_BABE;
        b.req1 = 1'b1; b.we1 = 1'b0; b.addr1 = 32'h20;
        #4;
        chk("col_gnt0", 32'(b.gnt0), 32'h1);
        chk("col_gnt1", 32'(b.gnt1), 32'h0);
        cyc();
        b.req0 = 1'b0;
        #4;
        chk("col_gnt1_next", 32'(b.gnt1), 32'h1);
        chk("col_m_read", 32'(b.m_read), 32'h1);
        cyc();
        b.req1 = 1'b0;
        #4;
        chk("col_rvalid1", 32'(b.rvalid1), 32'h1);
        chk("col_rdata1", b.rdata1, 32'hCAFE_BABE);

        // starvation; the second run shows the counter restarted from 0
        cyc();
        #4;
        starve_run("starve_first");
        starve_run("starve_again");
        cyc();
        b.req0 = 1'b0;
        #4;

        // reset during RD_WAIT drops the read return
        cyc();
        b.req1 = 1'b1; b.we1 = 1'b0; b.addr1 = 32'h20;
        #4;
        chk("mid_gnt1", 32'(b.gnt1), 32'h1);
        cyc();
        b.req1 = 1'b0; rst = 1'b1;
        #4;
        chk("mid_rvalid1", 32'(b.rvalid1), 32'h0);
        chk("mid_busy", 32'(b.busy), 32'h0);
        cyc();
        rst = 1'b0;
        b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 32'h30; b.wdata0 = 32'h1234_5678;
        #4;
        chk("mid_idle_busy", 32'(b.busy), 32'h0);
        chk("mid_idle_gnt0", 32'(b.gnt0), 32'h1);

        // back-to-back writes
        for (int i = 0; i < 3; i++) begin
            cyc();
            b.req0 = 1'b1; b.we0 = 1'b1;
            b.addr0 = 32'h50 + 32'(4 * i); b.wdata0 = 32'hA000_0000 + 32'(i);
            #4;
            chk("b2b_gnt0", 32'(b.gnt0), 32'h1);
            chk("b2b_m_write", 32'(b.m_write), 32'h1);
        end
        cyc();
        b.we0 = 1'b0; b.addr0 = 32'h54;
        #4;
        chk("b2b_rd_gnt0", 32'(b.gnt0), 32'h1);
        cyc();
        b.req0 = 1'b0;
        #4;
        chk("b2b_rdata0", b.rdata0, 32'hA000_0001);

        // read back the word written right after the reset
        cyc();
        b.req0 = 1'b1; b.we0 = 1'b0; b.addr0 = 32'h30;
        #4;
        cyc();
        b.req0 = 1'b0;
        #4;
        chk("rd30_rdata0", b.rdata0, 32'h1234_5678);
        cyc();
        #4;
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported `Data_mem` between the CPU memory stage (port 0) and the UART program/data loader (port 1). It sequences one access at a time: a write takes one memory cycle, and a read takes two (issue, then data return). Port 0 has fixed priority, and a wait counter keeps port 1 from starving. The block sits between the pipeline/loader and `Data_mem`, driving its `m_read`, `m_write`, `addr` and `d_in`, and returning `d_out`.

## Interface
- `ADDR_W`, 32, address width passed to `Data_mem`
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, number of consecutive cycles port 1 waits before it gets priority (≥1)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  access request, held with the payload until `gnt`
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  ADDR_W  byte address, passed through unmodified
- `wdata0` / `wdata1`  in  DATA_W  write data
- `gnt0` / `gnt1`  out  1  request accepted this cycle (combinational, from state and requests)
- `rvalid0` / `rvalid1`  out  1  read data valid this cycle
- `rdata0` / `rdata1`  out  DATA_W  read data (`d_out` routed to the owner; 0 otherwise)
- `busy`  out  1  high in RD_WAIT
- `m_read`, `m_write`  out  1  memory strobes
- `addr`  out  ADDR_W  memory address
- `d_in`  out  DATA_W  memory write data
- `d_out`  in  DATA_W  memory read data, valid on the cycle after `m_read`

## Operation
- FSM states:
  - IDLE: can grant.
  - RD_WAIT: a read is outstanding; `owner` register records 0 or 1.
- Arbitration in IDLE:
  - Port 1 wins if `req1` and (`!req0` or `starve_cnt` == STARVE_LIMIT).
  - Otherwise port 0 wins if `req0`.
  - At most one `gnt` per cycle; no grant when neither port requests.
- Grant cycle:
  - `addr`/`d_in` are driven from the winner.
  - `m_write` = winner `we`; `m_read` = !winner `we`.
- Write grant: stay in IDLE, so back-to-back grants are possible on consecutive cycles.
- Read grant: go to RD_WAIT and latch `owner`.
- RD_WAIT:
  - No grant; `m_read` = `m_write` = 0.
  - `rvalid[owner]` = 1 and `rdata[owner]` = `d_out`.
  - Return to IDLE next edge.
- `starve_cnt` (saturating at STARVE_LIMIT):
  - Increments each cycle `req1` is high and `gnt1` is low, including RD_WAIT cycles.
  - Clears on `gnt1` or on `!req1`.
- When not granted: `addr` and `d_in` are 0, and both strobes are 0.
- Reset:
  - All outputs are 0, state is IDLE, `starve_cnt` = 0, `owner` = 0.
  - Reset asserted during RD_WAIT abandons the read: no `rvalid` is produced.
- A requester dropping `req` before `gnt` is legal; the request is simply withdrawn.

## Timing
- Write: request in cycle T with IDLE gives `gnt` and `m_write` in T. The memory captures at the end of T. The requester may present its next request in T+1.
- Read: `gnt` and `m_read` in T; `rvalid` and `rdata` in T+1. The next grant is possible at T+2 at the earliest.
- Worst-case port 1 wait under continuous port-0 reads: ≤ 2·(STARVE_LIMIT+1) cycles.
- `gnt`, strobes, `addr` and `d_in` are combinational from state, `req*` and `starve_cnt`. `rvalid`/`rdata` are combinational from state, `owner` and `d_out`. All registers update only on `clk`.

## Test plan
- Reset: hold `rst` 2 cycles with both `req` high → all outputs 0, no `m_write`. Release → port 0 granted on the first IDLE cycle.
- Port 0 write then read:
  - Write `addr0`=0x10, `wdata0`=0xDEADBEEF → `gnt0` and `m_write` in the same cycle, `d_in`=0xDEADBEEF.
  - Read 0x10 → `gnt0`+`m_read`, then next cycle `rvalid0`=1 and `rdata0`=0xDEADBEEF, with `rvalid1`=0 and `rdata1`=0.
- Collision: `req0` write to 0x20 (0xCAFEBABE) and `req1` read of 0x20 in the same cycle → `gnt0` first. `gnt1` on the next cycle; the following cycle gives `rvalid1` with 0xCAFEBABE.
- Starvation: `req0` reads held continuously, `req1` held, STARVE_LIMIT=4 → `starve_cnt` reaches 4, then `gnt1` occurs at the next IDLE cycle despite `req0`. The counter is 0 afterwards.
- Reset mid-read: `gnt1` read, then `rst` asserted in the RD_WAIT cycle → no `rvalid1`. The FSM is in IDLE the cycle after `rst` falls.
- Back-to-back writes: `req0` writes on 3 consecutive cycles → `gnt0` in each of the 3 cycles with no bubbles.
